// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and stall signals around the unified memory
// port arbiter. 'master' is the arbiter's view, 'slave' is the environment
// (IF/MEM stages plus memory) view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  // data requester
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_done;
  // memory side
  logic              mem_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  // pipeline freeze
  logic              stall_f;
  logic              stall_m;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
           mem_ready, mem_rvalid, mem_rdata,
    output if_rdata, if_done, dm_rdata, dm_done,
           mem_valid, mem_we, mem_addr, mem_wdata, stall_f, stall_m
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
           mem_ready, mem_rvalid, mem_rdata,
    input  if_rdata, if_done, dm_rdata, dm_done,
           mem_valid, mem_we, mem_addr, mem_wdata, stall_f, stall_m
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data memory.
// One transaction in flight; data wins ties unless fetch has already lost
// STARVE_LIMIT consecutive decisions while waiting.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
);
  localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state_q,     state_d;
  logic              gnt_dm_q,    gnt_dm_d;
  logic [CNT_W-1:0]  starve_q,    starve_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_done_q,   if_done_d;
  logic              dm_done_q,   dm_done_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
  logic              pick_dm;

  // Data wins unless fetch is also waiting and has hit the starvation limit.
  always_comb pick_dm = bus.dm_req & ~(bus.if_req & (starve_q == LIMIT));

  // Next-state and registered-output computation for the transaction sequencer.
  always_comb begin
    state_d     = state_q;
    gnt_dm_d    = gnt_dm_q;
    starve_d    = starve_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      IDLE: begin
        // Counter only moves on a data win that left fetch waiting.
        if (pick_dm && bus.if_req) begin
          if (starve_q != LIMIT) starve_d = starve_q + 1'b1;
        end else begin
          starve_d = '0;
        end
        if (bus.if_req || bus.dm_req) begin
          gnt_dm_d    = pick_dm;
          mem_valid_d = 1'b1;
          mem_we_d    = pick_dm ? bus.dm_we    : 1'b0;
          mem_addr_d  = pick_dm ? bus.dm_addr  : bus.if_addr;
          mem_wdata_d = pick_dm ? bus.dm_wdata : '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // Command fields are frozen until the memory takes them.
        if (bus.mem_ready) begin
          mem_valid_d = 1'b0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          if (gnt_dm_q) begin
            dm_done_d = 1'b1;
            // Stores only need the ack; keep the last load value visible.
            if (!mem_we_q) dm_rdata_d = bus.mem_rdata;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        // Requester updates its request now; IDLE sees it next cycle.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_dm_q    <= 1'b0;
      starve_q    <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_dm_q    <= gnt_dm_d;
      starve_q    <= starve_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.dm_done   = dm_done_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;

  // Stalls drop in the done cycle so the stage advances with the result.
  assign bus.stall_f = bus.if_req & ~if_done_q;
  assign bus.stall_m = bus.dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random requesters and memory around mem_port_arbiter, checked each cycle
// against a transaction-level model of the grant/starvation rules.
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LIM  = 4;
  localparam int NCYC = 4000;
  localparam int SAT  = 600;   // cycles with both requesters always busy

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs as seen by the DUT at the last rising edge.
  logic          l_rst, l_if_req, l_dm_req, l_dm_we, l_ready, l_rvalid;
  logic [AW-1:0] l_if_addr, l_dm_addr;
  logic [DW-1:0] l_dm_wdata, l_rdata;

  // Reference model: 0 free, 1 command offered, 2 accepted, 3 completing.
  int            stage, starve, n_done, starve_hits, n_f_grant, n_d_grant;
  bit            gnt_data, did_wait_rst, force_rv;
  logic          e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, m_if_rdata, m_dm_rdata;

  task automatic snapshot();
    l_rst      = rst;
    l_if_req   = bus.if_req;
    l_if_addr  = bus.if_addr;
    l_dm_req   = bus.dm_req;
    l_dm_we    = bus.dm_we;
    l_dm_addr  = bus.dm_addr;
    l_dm_wdata = bus.dm_wdata;
    l_ready    = bus.mem_ready;
    l_rvalid   = bus.mem_rvalid;
    l_rdata    = bus.mem_rdata;
  endtask

  task automatic observe();
    bit e_mv, e_fd, e_dd, chk_cmd;
    e_mv = 0; e_fd = 0; e_dd = 0; chk_cmd = 0;
    if (l_rst) begin
      stage = 0; starve = 0;
      m_if_rdata = '0; m_dm_rdata = '0;
      e_we = 1'b0; e_addr = '0; e_wdata = '0;
      chk_cmd = 1;
    end else begin
      case (stage)
        0: begin
          if (l_if_req || l_dm_req) begin
            gnt_data = l_dm_req && !(l_if_req && starve == LIM);
            if (l_if_req && l_dm_req && starve == LIM) starve_hits++;
            if (gnt_data) n_d_grant++; else n_f_grant++;
            e_we    = gnt_data ? l_dm_we : 1'b0;
            e_addr  = gnt_data ? l_dm_addr : l_if_addr;
            e_wdata = gnt_data ? l_dm_wdata : '0;
            e_mv = 1; chk_cmd = 1; stage = 1;
          end
          if (gnt_data && l_if_req && (l_if_req || l_dm_req))
            starve = (starve < LIM) ? starve + 1 : LIM;
          else
            starve = 0;
        end
        1: begin
          if (l_ready) stage = 2;
          else begin e_mv = 1; chk_cmd = 1; end
        end
        2: begin
          if (l_rvalid) begin
            stage = 3;
            n_done++;
            if (gnt_data) begin
              e_dd = 1;
              if (!e_we) m_dm_rdata = l_rdata;
            end else begin
              e_fd = 1;
              m_if_rdata = l_rdata;
            end
          end
        end
        default: stage = 0;
      endcase
    end
    chk("mem_valid", bus.mem_valid, e_mv);
    if (chk_cmd) begin
      chk("mem_we",    bus.mem_we,    e_we);
      chk("mem_addr",  bus.mem_addr,  e_addr);
      chk("mem_wdata", bus.mem_wdata, e_wdata);
    end
    chk("if_done",  bus.if_done,  e_fd);
    chk("dm_done",  bus.dm_done,  e_dd);
    chk("if_rdata", bus.if_rdata, m_if_rdata);
    chk("dm_rdata", bus.dm_rdata, m_dm_rdata);
    chk("stall_f",  bus.stall_f,  l_if_req & ~e_fd);
    chk("stall_m",  bus.stall_m,  l_dm_req & ~e_dd);
  endtask

  task automatic drive(input int cyc);
    bit sat;
    sat = (cyc < SAT);
    rst = 1'b0;
    // One reset landed while a response is awaited, then a late response.
    if (!sat && !did_wait_rst && stage == 2) begin
      rst = 1'b1; did_wait_rst = 1; force_rv = 1;
    end else if (!sat && $urandom_range(0, 249) == 0) begin
      rst = 1'b1;
    end
    // fetch requester
    if (bus.if_req && bus.if_done) begin
      if (sat || $urandom_range(0, 1) == 1) bus.if_addr = $urandom;
      else bus.if_req = 1'b0;
    end else if (!bus.if_req && (sat || $urandom_range(0, 3) == 0)) begin
      bus.if_req  = 1'b1;
      bus.if_addr = $urandom;
    end
    // data requester
    if (bus.dm_req && bus.dm_done) begin
      if (sat || $urandom_range(0, 1) == 1) begin
        bus.dm_we = 1'($urandom_range(0, 1)); bus.dm_addr = $urandom; bus.dm_wdata = $urandom;
      end else bus.dm_req = 1'b0;
    end else if (!bus.dm_req && (sat || $urandom_range(0, 2) == 0)) begin
      bus.dm_req = 1'b1;
      bus.dm_we = 1'($urandom_range(0, 1)); bus.dm_addr = $urandom; bus.dm_wdata = $urandom;
    end
    // memory: random backpressure, random response delay, stray responses
    bus.mem_ready = ($urandom_range(0, 2) != 0);
    if (force_rv && !rst) begin
      bus.mem_rvalid = 1'b1; force_rv = 0;
    end else if (stage == 2) begin
      bus.mem_rvalid = ($urandom_range(0, 2) == 0);
    end else begin
      bus.mem_rvalid = ($urandom_range(0, 4) == 0);
    end
    bus.mem_rdata = $urandom;
  endtask

  initial begin
    stage = 0; starve = 0; n_done = 0; starve_hits = 0; n_f_grant = 0; n_d_grant = 0;
    gnt_data = 0; did_wait_rst = 0; force_rv = 0;
    e_we = 0; e_addr = '0; e_wdata = '0; m_if_rdata = '0; m_dm_rdata = '0;
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    snapshot();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      observe();
      drive(cyc);
      snapshot();
    end
    chk("progress",      n_done > 100, 1'b1);
    chk("starve_hit",    starve_hits > 0, 1'b1);
    chk("fetch_granted", n_f_grant > 0, 1'b1);
    chk("data_granted",  n_d_grant > n_f_grant / 4, 1'b1);
    chk("wait_reset",    did_wait_rst, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
